// File: rtl/qos_pkg.sv
// Shared constants and types for the QoS read scheduler.
// Higher queue index means higher priority. The top index is the high-bandwidth queue.
package qos_pkg;

    localparam int DSIZE   = 32;
    localparam int NQ      = 5;
    localparam int QWIDTH  = 3;
    localparam int AWIDTH  = 4;
    localparam int HIBW_Q  = NQ - 1;
    localparam int AGE_MAX = 15;

    typedef logic [QWIDTH-1:0] qid_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/qos_age_arbiter.sv
// Strict-priority pop arbiter. Per-queue aging counters force-grant a starving low-priority queue.
import qos_pkg::*;

module qos_age_arbiter #(
    parameter int NQ      = qos_pkg::NQ,
    parameter int AWIDTH  = qos_pkg::AWIDTH,
    parameter int AGE_MAX = qos_pkg::AGE_MAX
) (
    input  logic          iClk,
    input  logic          iReset,
    input  logic [NQ-1:0] iEligible,
    input  logic          iPopOk,
    output logic [NQ-1:0] oGrant,
    output logic          oAged
);

    localparam int HI = NQ - 1;
    localparam logic [AWIDTH-1:0] AGE_TOP = AWIDTH'(AGE_MAX);

    // The high-bandwidth queue never ages, so it has no counter.
    logic [AWIDTH-1:0] ageReg [HI];
    logic [NQ-1:0]     agedHit;
    logic              anyGrant;

    generate
        for (genvar gi = 0; gi < HI; gi++) begin : g_hit
            assign agedHit[gi] = iEligible[gi] && (ageReg[gi] == AGE_TOP);
        end
    endgenerate
    assign agedHit[HI] = 1'b0;

    always_comb begin
        oGrant = '0;
        oAged  = 1'b0;
        if (iPopOk && (|iEligible)) begin
            if (|agedHit) begin
                // A descending scan leaves the lowest aged queue as the winner.
                oAged = 1'b1;
                for (int q = HI - 1; q >= 0; q--) begin
                    if (agedHit[q]) begin
                        oGrant    = '0;
                        oGrant[q] = 1'b1;
                    end
                end
            end else begin
                for (int q = 0; q < NQ; q++) begin
                    if (iEligible[q]) begin
                        oGrant    = '0;
                        oGrant[q] = 1'b1;
                    end
                end
            end
        end
    end

    assign anyGrant = |oGrant;

    always_ff @(posedge iClk) begin
        for (int q = 0; q < HI; q++) begin
            if (iReset || !iEligible[q]) begin
                ageReg[q] <= '0;
            end else if (anyGrant) begin
                if (oGrant[q]) begin
                    ageReg[q] <= '0;
                end else if (ageReg[q] != AGE_TOP) begin
                    ageReg[q] <= ageReg[q] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/qos_read_scheduler.sv
// Read-end scheduler: pops one FWFT queue per cycle into a registered valid/ready output stage.
import qos_pkg::*;

module qos_read_scheduler #(
    parameter int DSIZE   = qos_pkg::DSIZE,
    parameter int NQ      = qos_pkg::NQ,
    parameter int AGE_MAX = qos_pkg::AGE_MAX,
    parameter int AWIDTH  = qos_pkg::AWIDTH,
    parameter int QWIDTH  = qos_pkg::QWIDTH
) (
    input  logic               iClk,
    input  logic               iReset,
    input  logic [NQ-1:0]      iEmpty,
    input  logic [NQ*DSIZE-1:0] iRdData,
    output logic [NQ-1:0]      oRd,
    output logic [DSIZE-1:0]   oData,
    output logic               oValid,
    input  logic               iReady,
    output logic [QWIDTH-1:0]  oQid,
    output logic               oAged
);

    state_t             stateReg;
    state_t             stateNext;
    logic               popOk;
    logic [NQ-1:0]      grant;
    logic               grantAged;
    logic               anyPop;
    logic [DSIZE-1:0]   selData;
    logic [QWIDTH-1:0]  selQid;

    // Reset gates popOk so no queue loses a word during the reset cycle.
    assign popOk  = (~oValid | iReady) & ~iReset;
    assign anyPop = |grant;
    assign oRd    = grant;

    qos_age_arbiter #(
        .NQ      (NQ),
        .AWIDTH  (AWIDTH),
        .AGE_MAX (AGE_MAX)
    ) uArb (
        .iClk      (iClk),
        .iReset    (iReset),
        .iEligible (~iEmpty),
        .iPopOk    (popOk),
        .oGrant    (grant),
        .oAged     (grantAged)
    );

    always_comb begin
        selData = '0;
        selQid  = '0;
        for (int q = 0; q < NQ; q++) begin
            if (grant[q]) begin
                selData = selData | iRdData[q*DSIZE +: DSIZE];
                selQid  = QWIDTH'(q);
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            stateReg <= ST_EMPTY;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            ST_EMPTY: if (anyPop) stateNext = ST_FULL;
            ST_FULL:  if (iReady && !anyPop) stateNext = ST_EMPTY;
            default:  stateNext = ST_EMPTY;
        endcase
    end

    always_comb begin
        oValid = (stateReg == ST_FULL);
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            oData <= '0;
            oQid  <= '0;
            oAged <= 1'b0;
        end else if (anyPop) begin
            oData <= selData;
            oQid  <= selQid;
            oAged <= grantAged;
        end
    end

endmodule

// File: tb/tb_qos_read_scheduler.sv
// Directed bench for qos_read_scheduler with AGE_MAX=3: vector table plus reset and burst sequences.
module tb_qos_read_scheduler;

    logic         iClk;
    logic         iReset;
    logic [4:0]   iEmpty;
    logic [159:0] iRdData;
    logic [4:0]   oRd;
    logic [31:0]  oData;
    logic         oValid;
    logic         iReady;
    logic [2:0]   oQid;
    logic         oAged;

    int total;
    int bad;

    typedef struct {
        logic [4:0] empty;
        logic       ready;
        logic [4:0] expRd;
        logic       expValid;
        logic [2:0] expQid;
        logic       expAged;
    } vec_t;

    vec_t vecs[28];

    qos_read_scheduler #(
        .DSIZE   (32),
        .NQ      (5),
        .AGE_MAX (3),
        .AWIDTH  (4),
        .QWIDTH  (3)
    ) dut (
        .iClk    (iClk),
        .iReset  (iReset),
        .iEmpty  (iEmpty),
        .iRdData (iRdData),
        .oRd     (oRd),
        .oData   (oData),
        .oValid  (oValid),
        .iReady  (iReady),
        .oQid    (oQid),
        .oAged   (oAged)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] e, input logic r, input logic [4:0] rd,
                                input logic v, input logic [2:0] q, input logic a);
        vec_t t;
        t.empty = e; t.ready = r; t.expRd = rd; t.expValid = v; t.expQid = q; t.expAged = a;
        return t;
    endfunction

    logic [31:0] burst [4];
    logic [31:0] expData;

    initial begin
        total = 0;
        bad   = 0;

        // Priority, then aging with a 5-cycle stall in the middle of the 3,3,3,0 pattern.
        vecs[0]  = mk(5'b10101, 1'b1, 5'b01000, 1'b1, 3'd3, 1'b0);
        vecs[1]  = mk(5'b10110, 1'b1, 5'b01000, 1'b1, 3'd3, 1'b0);
        vecs[2]  = mk(5'b10110, 1'b1, 5'b01000, 1'b1, 3'd3, 1'b0);
        vecs[3]  = mk(5'b10110, 1'b1, 5'b01000, 1'b1, 3'd3, 1'b0);
        vecs[4]  = mk(5'b10110, 1'b1, 5'b00001, 1'b1, 3'd0, 1'b1);
        vecs[5]  = mk(5'b10110, 1'b1, 5'b01000, 1'b1, 3'd3, 1'b0);
        vecs[6]  = mk(5'b10110, 1'b1, 5'b01000, 1'b1, 3'd3, 1'b0);
        for (int i = 7; i < 12; i++)
            vecs[i] = mk(5'b10110, 1'b0, 5'b00000, 1'b1, 3'd3, 1'b0);
        vecs[12] = mk(5'b10110, 1'b1, 5'b01000, 1'b1, 3'd3, 1'b0);
        vecs[13] = mk(5'b10110, 1'b1, 5'b00001, 1'b1, 3'd0, 1'b1);
        // Drain, single word from queue 2, then prove its age restarted at 0.
        vecs[14] = mk(5'b11111, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0);
        vecs[15] = mk(5'b11111, 1'b0, 5'b00000, 1'b0, 3'd0, 1'b0);
        vecs[16] = mk(5'b11011, 1'b0, 5'b00100, 1'b1, 3'd2, 1'b0);
        vecs[17] = mk(5'b11111, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0);
        vecs[18] = mk(5'b01011, 1'b1, 5'b10000, 1'b1, 3'd4, 1'b0);
        vecs[19] = mk(5'b01011, 1'b1, 5'b10000, 1'b1, 3'd4, 1'b0);
        vecs[20] = mk(5'b01011, 1'b1, 5'b10000, 1'b1, 3'd4, 1'b0);
        vecs[21] = mk(5'b01011, 1'b1, 5'b00100, 1'b1, 3'd2, 1'b1);
        // Two queues reach AGE_MAX together: lowest wins, the other saturates and goes next.
        vecs[22] = mk(5'b01100, 1'b1, 5'b10000, 1'b1, 3'd4, 1'b0);
        vecs[23] = mk(5'b01100, 1'b1, 5'b10000, 1'b1, 3'd4, 1'b0);
        vecs[24] = mk(5'b01100, 1'b1, 5'b10000, 1'b1, 3'd4, 1'b0);
        vecs[25] = mk(5'b01100, 1'b1, 5'b00001, 1'b1, 3'd0, 1'b1);
        vecs[26] = mk(5'b01100, 1'b1, 5'b00010, 1'b1, 3'd1, 1'b1);
        vecs[27] = mk(5'b01100, 1'b1, 5'b10000, 1'b1, 3'd4, 1'b0);

        burst[0] = 32'h1111_0001;
        burst[1] = 32'h2222_0002;
        burst[2] = 32'h3333_0003;
        burst[3] = 32'h4444_0004;

        for (int q = 0; q < 5; q++)
            iRdData[q*32 +: 32] = 32'hA0 + 32'(q);
        iEmpty = 5'b00000;
        iReady = 1'b1;
        iReset = 1'b1;

        // Reset held two cycles with every queue non-empty.
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("reset_rd", 32'(oRd), 32'h0);
            @(posedge iClk); #1;
            chk("reset_valid", 32'(oValid), 32'h0);
            chk("reset_data", oData, 32'h0);
            chk("reset_qid", 32'(oQid), 32'h0);
            $display("reset cycle %0d: rd=%b valid=%b data=%h", c, oRd, oValid, oData);
        end
        iReset = 1'b0;
        #1;
        chk("release_rd", 32'(oRd), 32'h10);
        @(posedge iClk); #1;
        chk("release_valid", 32'(oValid), 32'h1);
        chk("release_data", oData, 32'hA4);
        $display("release: valid=%b qid=%0d data=%h", oValid, oQid, oData);

        // Reset while a word is held: it is dropped and no queue is popped.
        iReset = 1'b1;
        #1;
        chk("midreset_rd", 32'(oRd), 32'h0);
        @(posedge iClk); #1;
        chk("midreset_valid", 32'(oValid), 32'h0);
        chk("midreset_data", oData, 32'h0);
        $display("mid-transfer reset: valid=%b data=%h", oValid, oData);
        iReset = 1'b0;

        for (int i = 0; i < 28; i++) begin
            iEmpty = vecs[i].empty;
            iReady = vecs[i].ready;
            #1;
            chk($sformatf("v%0d_rd", i), 32'(oRd), 32'(vecs[i].expRd));
            @(posedge iClk); #1;
            chk($sformatf("v%0d_valid", i), 32'(oValid), 32'(vecs[i].expValid));
            if (vecs[i].expValid) begin
                expData = 32'hA0 + 32'(vecs[i].expQid);
                chk($sformatf("v%0d_qid", i), 32'(oQid), 32'(vecs[i].expQid));
                chk($sformatf("v%0d_aged", i), 32'(oAged), 32'(vecs[i].expAged));
                chk($sformatf("v%0d_data", i), oData, expData);
            end
            $display("vec %0d: empty=%b ready=%b rd=%b -> valid=%b qid=%0d aged=%b data=%h",
                     i, vecs[i].empty, vecs[i].ready, vecs[i].expRd, oValid, oQid, oAged, oData);
        end

        // Queue 4 delivers four words back to back, then runs dry.
        iReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                iEmpty = 5'b01111;
                iRdData[4*32 +: 32] = burst[k];
            end else begin
                iEmpty = 5'b11111;
            end
            #1;
            chk($sformatf("burst%0d_rd", k), 32'(oRd), (k < 4) ? 32'h10 : 32'h0);
            @(posedge iClk); #1;
            chk($sformatf("burst%0d_valid", k), 32'(oValid), (k < 4) ? 32'h1 : 32'h0);
            if (k < 4) chk($sformatf("burst%0d_data", k), oData, burst[k]);
            $display("burst %0d: valid=%b qid=%0d data=%h", k, oValid, oQid, oData);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
